// File: rtl/stage_if_pq_if.sv
// ---------------------------------------------------------------------------
// stage_if_pq_if
// Instruction-memory fetch bus between the fetch stage and instruction memory.
//
// Signals
//   ireq    fetch request valid (fetch -> memory)
//   iaddr   fetch address, word aligned (fetch -> memory)
//   igrant  request accepted this cycle when ireq && igrant (memory -> fetch)
//   ivalid  in-order response valid, at least one cycle after grant
//   idata   response instruction word
//
// Modports
//   master  fetch stage side
//   slave   memory side
// ---------------------------------------------------------------------------
interface stage_if_pq_if;
    logic        ireq;
    logic [31:0] iaddr;
    logic        igrant;
    logic        ivalid;
    logic [31:0] idata;

    modport master (
        output ireq,
        output iaddr,
        input  igrant,
        input  ivalid,
        input  idata
    );

    modport slave (
        input  ireq,
        input  iaddr,
        output igrant,
        output ivalid,
        output idata
    );
endinterface

// File: rtl/stage_if_pq.sv
// ---------------------------------------------------------------------------
// stage_if_pq
// Instruction fetch stage with a prefetch queue. A fetch pointer issues
// sequential word requests to memory; in-order responses are pushed to a
// small queue whose head is presented to decode. Branch and exception
// redirects flush the queue, retarget the fetch pointer and turn every
// request still in flight into a discard.
//
// Parameters
//   RESET_VEC  reset fetch address and exception vector base
//   DEPTH      prefetch queue entries (power of 2, 2..16)
//   MAX_OUT    max outstanding memory requests (1..DEPTH)
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   exn, exn_type    exception redirect and vector index (highest priority)
//   eret, elr        with exn: return to elr instead of the vector
//   br, br_dest      branch redirect from decode (ignored while stall)
//   stall            decode cannot accept the queue head
//   mem              fetch bus (stage_if_pq_if.master)
//   out_valid        queue head valid
//   out_pc           head pc (holds last shown value while empty)
//   out_instr        head instruction (holds last shown value while empty)
//   out_misalign     head came from a misaligned redirect target
//                    (only with STAGE_IF_PQ_ALIGN_CHK_EN)
//   out_bubble       !out_valid || br || exn
//
// Build option
//   STAGE_IF_PQ_ALIGN_CHK_EN  defined: a misaligned redirect target pushes a
//   single marked entry and halts fetching until the next redirect.
//   Undefined: target bits [1:0] are forced to zero.
// ---------------------------------------------------------------------------
module stage_if_pq #(
    parameter logic [31:0] RESET_VEC = 32'h0,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUT   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          exn,
    input  logic [5:0]    exn_type,
    input  logic          eret,
    input  logic [31:0]   elr,
    input  logic          br,
    input  logic [31:0]   br_dest,
    input  logic          stall,
    stage_if_pq_if.master mem,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
`ifdef STAGE_IF_PQ_ALIGN_CHK_EN
    output logic          out_misalign,
`endif
    output logic          out_bubble
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW:0] MAXO_W  = (CW + 1)'(MAX_OUT);

    // control state
    logic [31:0]   fpc;
    logic [31:0]   resp_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] live;
    logic [CW-1:0] disc;
    logic          halt;
    logic [31:0]   hold_pc;
    logic [31:0]   hold_instr;

    // queue storage
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
`ifdef STAGE_IF_PQ_ALIGN_CHK_EN
    logic          q_mis   [DEPTH];
    logic          tgt_mis;
`endif

    logic          redir;
    logic          room;
    logic          slot;
    logic          grant;
    logic          ret_live;
    logic          ret_disc;
    logic          push;
    logic          pop;
    logic [31:0]   target;
    logic [31:0]   target_fix;

    always_comb begin
        target = br_dest;
        if (exn) begin
            target = eret ? elr : {RESET_VEC[31:8], exn_type, 2'b00};
        end
    end

    always_comb begin
        target_fix = target;
`ifndef STAGE_IF_PQ_ALIGN_CHK_EN
        target_fix[1:0] = 2'b00;
`endif
    end

`ifdef STAGE_IF_PQ_ALIGN_CHK_EN
    assign tgt_mis = |target[1:0];
`endif

    assign redir = exn || (br && !stall);

    // Queue space is reserved for live requests only; discards never push,
    // but they still occupy memory-side slots.
    assign room = ({1'b0, count} + {1'b0, live}) < DEPTH_W;
    assign slot = ({1'b0, live} + {1'b0, disc}) < MAXO_W;

    // rst_n gates ireq so no request is visible while reset is held.
    assign mem.ireq  = rst_n && !redir && !halt && room && slot;
    assign mem.iaddr = fpc;
    assign grant     = mem.ireq && mem.igrant;

    // Responses are in order, so pending discards are always the oldest.
    assign ret_disc = mem.ivalid && (disc != '0);
    assign ret_live = mem.ivalid && (disc == '0);
    assign push     = ret_live && !redir;

    assign out_valid  = (count != '0);
    assign pop        = out_valid && !stall && !br && !exn;
    assign out_pc     = out_valid ? q_pc[rd_ptr]    : hold_pc;
    assign out_instr  = out_valid ? q_instr[rd_ptr] : hold_instr;
    assign out_bubble = !out_valid || br || exn;
`ifdef STAGE_IF_PQ_ALIGN_CHK_EN
    assign out_misalign = out_valid && q_mis[rd_ptr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc     <= RESET_VEC;
            resp_pc <= RESET_VEC;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            live    <= '0;
            disc    <= '0;
        end else if (redir) begin
            fpc     <= target_fix;
            resp_pc <= target_fix;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            live    <= '0;
            // A response arriving in the redirect cycle retires one of the
            // in-flight requests, discard or live alike.
            disc    <= disc + live - CW'(mem.ivalid);
`ifdef STAGE_IF_PQ_ALIGN_CHK_EN
            if (tgt_mis) begin
                wr_ptr <= PW'(1);
                count  <= CW'(1);
            end
`endif
        end else begin
            if (grant) begin
                fpc <= fpc + 32'd4;
            end
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            live  <= live + CW'(grant) - CW'(ret_live);
            disc  <= disc - CW'(ret_disc);
        end
    end

`ifdef STAGE_IF_PQ_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt <= 1'b0;
        end else if (redir) begin
            halt <= tgt_mis;
        end
    end
`else
    assign halt = 1'b0;
`endif

    // Last shown head, presented while the queue is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_pc    <= '0;
            hold_instr <= '0;
        end else if (out_valid) begin
            hold_pc    <= q_pc[rd_ptr];
            hold_instr <= q_instr[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= resp_pc;
            q_instr[wr_ptr] <= mem.idata;
`ifdef STAGE_IF_PQ_ALIGN_CHK_EN
            q_mis[wr_ptr]   <= 1'b0;
`endif
        end
`ifdef STAGE_IF_PQ_ALIGN_CHK_EN
        if (redir && tgt_mis) begin
            q_pc[0]    <= target;
            q_instr[0] <= '0;
            q_mis[0]   <= 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_stage_if_pq.sv
// ---------------------------------------------------------------------------
// tb_stage_if_pq
// Scoreboard bench for stage_if_pq (RESET_VEC=0x100, DEPTH=4, MAX_OUT=2).
// A behavioural memory answers grants in order; a reference model predicts
// fetch addresses, queue contents and request eligibility.
// ---------------------------------------------------------------------------
module tb_stage_if_pq;
    localparam logic [31:0] RV      = 32'h100;
    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        drop;
    } fl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exn = 1'b0;
    logic [5:0]  exn_type = 6'h0;
    logic        eret = 1'b0;
    logic [31:0] elr = 32'h0;
    logic        br = 1'b0;
    logic [31:0] br_dest = 32'h0;
    logic        stall = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_bubble;
`ifdef STAGE_IF_PQ_ALIGN_CHK_EN
    logic        out_misalign;
`endif

    stage_if_pq_if mem_bus ();

    stage_if_pq #(
        .RESET_VEC (RV),
        .DEPTH     (DEPTH),
        .MAX_OUT   (MAX_OUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exn          (exn),
        .exn_type     (exn_type),
        .eret         (eret),
        .elr          (elr),
        .br           (br),
        .br_dest      (br_dest),
        .stall        (stall),
        .mem          (mem_bus),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
`ifdef STAGE_IF_PQ_ALIGN_CHK_EN
        .out_misalign (out_misalign),
`endif
        .out_bubble   (out_bubble)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    ent_t        exp_q[$];
    fl_t         infl[$];
    logic [31:0] mem_q[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];
    logic        pop_mis[$];
    int          pop_cyc[$];
    logic [31:0] grant_addr[$];
    logic [31:0] exp_fpc = RV;
    logic [31:0] last_pc = 32'h0;
    logic [31:0] last_instr = 32'h0;
    bit          halted = 1'b0;
    bit          mem_hold = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: check/model at negedge, drive memory after posedge.
    task automatic cycle();
        bit          redir;
        bit          exp_ireq;
        int          live;
        ent_t        e;
        fl_t         f;
        logic [31:0] t;
        @(negedge clk);
        redir = exn || (br && !stall);
        live = 0;
        foreach (infl[i]) if (!infl[i].drop) live++;
        exp_ireq = !redir && !halted && (exp_q.size() + live < DEPTH) && (infl.size() < MAX_OUT);
        check("ireq", 32'(mem_bus.ireq), 32'(exp_ireq));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("out_bubble", 32'(out_bubble), 32'(!out_valid || br || exn));
        if (exp_q.size() == 0) begin
            check("hold_pc", out_pc, last_pc);
            check("hold_instr", out_instr, last_instr);
        end else begin
            last_pc    = exp_q[0].pc;
            last_instr = exp_q[0].instr;
        end
        if (out_valid && !stall && !br && !exn && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("head_pc", out_pc, e.pc);
            check("head_instr", out_instr, e.instr);
`ifdef STAGE_IF_PQ_ALIGN_CHK_EN
            check("head_mis", 32'(out_misalign), 32'(e.mis));
            pop_mis.push_back(out_misalign);
`else
            pop_mis.push_back(1'b0);
`endif
            pop_pc.push_back(out_pc);
            pop_instr.push_back(out_instr);
            pop_cyc.push_back(cyc);
        end
        if (mem_bus.ivalid && infl.size() != 0) begin
            f = infl.pop_front();
            if (!f.drop && !redir) exp_q.push_back('{f.addr, mem_word(f.addr), 1'b0});
        end
        if (redir) begin
            exp_q.delete();
            foreach (infl[i]) infl[i].drop = 1'b1;
            if (exn) t = eret ? elr : {RV[31:8], exn_type, 2'b00};
            else     t = br_dest;
`ifdef STAGE_IF_PQ_ALIGN_CHK_EN
            halted = (t[1:0] != 2'b00);
            if (halted) exp_q.push_back('{t, 32'h0, 1'b1});
`else
            t[1:0] = 2'b00;
`endif
            exp_fpc = t;
        end
        if (mem_bus.ireq && mem_bus.igrant) begin
            check("iaddr", mem_bus.iaddr, exp_fpc);
            infl.push_back('{exp_fpc, 1'b0});
            mem_q.push_back(mem_bus.iaddr);
            grant_addr.push_back(mem_bus.iaddr);
            exp_fpc = exp_fpc + 32'd4;
        end
        @(posedge clk);
        #1;
        if (!mem_hold && mem_q.size() != 0) begin
            mem_bus.ivalid = 1'b1;
            mem_bus.idata  = mem_word(mem_q.pop_front());
        end else begin
            mem_bus.ivalid = 1'b0;
            mem_bus.idata  = 32'h0;
        end
        cyc++;
    endtask

    task automatic wait_pops(input int n, input int max_cyc);
        int base;
        base = pop_pc.size();
        for (int i = 0; i < max_cyc && pop_pc.size() < base + n; i++) cycle();
        check("wait_pops", 32'(pop_pc.size() - base), 32'(n));
    endtask

    task automatic wait_grants(input int n, input int max_cyc);
        int base;
        base = grant_addr.size();
        for (int i = 0; i < max_cyc && grant_addr.size() < base + n; i++) cycle();
        check("wait_grants", 32'(grant_addr.size() - base), 32'(n));
    endtask

    initial begin
        int p0;
        int g0;
        mem_bus.igrant = 1'b1;
        // Junk response during reset must be ignored.
        mem_bus.ivalid = 1'b1;
        mem_bus.idata  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ireq", 32'(mem_bus.ireq), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_iaddr", mem_bus.iaddr, RV);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_bubble", 32'(out_bubble), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_bus.ivalid = 1'b0;
        mem_bus.idata  = 32'h0;

        // Streaming after reset: 0x100, 0x104, 0x108 on consecutive cycles.
        repeat (8) cycle();
        check("seq_count", 32'(pop_pc.size() >= 3), 32'h1);
        if (pop_pc.size() >= 3) begin
            check("seq_pc0", pop_pc[0], 32'h100);
            check("seq_pc1", pop_pc[1], 32'h104);
            check("seq_pc2", pop_pc[2], 32'h108);
            check("seq_first_cyc", 32'(pop_cyc[0]), 32'd2);
            check("seq_consec1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
            check("seq_consec2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
        end

        // Stall: queue fills, fetching stops; branch under stall is ignored.
        stall = 1'b1;
        repeat (6) cycle();
        br = 1'b1;
        br_dest = 32'h3000;
        cycle();
        br = 1'b0;
        check("br_stall_kept", 32'(out_valid), 32'h1);
        g0 = grant_addr.size();
        repeat (4) cycle();
        check("stall_no_grant", 32'(grant_addr.size() - g0), 32'h0);
        stall = 1'b0;
        p0 = pop_pc.size();
        g0 = grant_addr.size();
        repeat (4) cycle();
        check("release_pops", 32'(pop_pc.size() - p0), 32'd4);
        check("release_refetch", 32'(grant_addr.size() > g0), 32'h1);

        // Branch with two requests in flight: both responses discarded.
        mem_hold = 1'b1;
        repeat (6) cycle();
        check("inflight_two", 32'(infl.size()), 32'd2);
        br = 1'b1;
        br_dest = 32'h2000;
        cycle();
        br = 1'b0;
        mem_hold = 1'b0;
        p0 = pop_pc.size();
        wait_pops(1, 20);
        if (pop_pc.size() > p0) check("br_target_pc", pop_pc[p0], 32'h2000);

        // Exception beats branch and stall.
        repeat (3) cycle();
        exn = 1'b1;
        exn_type = 6'h05;
        br = 1'b1;
        br_dest = 32'h4000;
        stall = 1'b1;
        g0 = grant_addr.size();
        cycle();
        exn = 1'b0;
        br = 1'b0;
        stall = 1'b0;
        wait_grants(1, 20);
        if (grant_addr.size() > g0) check("exn_vector", grant_addr[g0], {RV[31:8], 8'h14});

        // eret to the top of the address space wraps to zero.
        repeat (3) cycle();
        exn = 1'b1;
        eret = 1'b1;
        elr = 32'hFFFF_FFFC;
        cycle();
        exn = 1'b0;
        eret = 1'b0;
        p0 = pop_pc.size();
        wait_pops(2, 30);
        if (pop_pc.size() >= p0 + 2) begin
            check("eret_pc0", pop_pc[p0], 32'hFFFF_FFFC);
            check("eret_pc1", pop_pc[p0 + 1], 32'h0000_0000);
        end

        // Misaligned branch target.
        repeat (3) cycle();
        br = 1'b1;
        br_dest = 32'h2002;
        cycle();
        br = 1'b0;
        p0 = pop_pc.size();
`ifdef STAGE_IF_PQ_ALIGN_CHK_EN
        wait_pops(1, 10);
        if (pop_pc.size() > p0) begin
            check("mis_pc", pop_pc[p0], 32'h2002);
            check("mis_instr", pop_instr[p0], 32'h0);
            check("mis_flag", 32'(pop_mis[p0]), 32'h1);
        end
        g0 = grant_addr.size();
        repeat (10) cycle();
        check("mis_halt", 32'(grant_addr.size() - g0), 32'h0);
        br = 1'b1;
        br_dest = 32'h3000;
        cycle();
        br = 1'b0;
        p0 = pop_pc.size();
        wait_pops(1, 20);
        if (pop_pc.size() > p0) check("mis_resume", pop_pc[p0], 32'h3000);
`else
        wait_pops(1, 20);
        if (pop_pc.size() > p0) check("mis_forced", pop_pc[p0], 32'h2000);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            stall          = ($urandom_range(0, 3) == 0);
            br             = ($urandom_range(0, 29) == 0);
            br_dest        = $urandom();
            exn            = ($urandom_range(0, 59) == 0);
            exn_type       = 6'($urandom());
            eret           = $urandom_range(0, 1) == 1;
            elr            = $urandom();
            mem_hold       = ($urandom_range(0, 2) == 0);
            mem_bus.igrant = ($urandom_range(0, 3) != 0);
            cycle();
        end
        stall = 1'b0;
        br = 1'b0;
        exn = 1'b0;
        eret = 1'b0;
        mem_hold = 1'b0;
        mem_bus.igrant = 1'b1;
        repeat (20) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stage_if_pq.md
STAGE_IF_PQ -- requirements
Module: stage_if_pq

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0, reset fetch address and exception vector base.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries; legal values are powers of 2 from 2 to 16.
REQ-003 SHALL have parameter MAX_OUT, default 2, maximum outstanding memory requests; legal values are 1 to DEPTH.
REQ-004 Port clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 Port exn  in  1  exception or eret redirect, highest priority.
REQ-007 Port exn_type  in  6  exception vector index.
REQ-008 Port eret  in  1  with exn, return to elr.
REQ-009 Port elr  in  32  exception return address.
REQ-010 Port br  in  1  branch redirect from decode.
REQ-011 Port br_dest  in  32  branch target.
REQ-012 Port stall  in  1  decode cannot accept the queue head.
REQ-013 Port ireq  out  1  memory fetch request valid.
REQ-014 Port iaddr  out  32  memory fetch address.
REQ-015 Port igrant  in  1  request accepted when ireq&&igrant.
REQ-016 Port ivalid  in  1  in-order response valid, at least 1 cycle after grant.
REQ-017 Port idata  in  32  response instruction word.
REQ-018 Port out_valid  out  1  queue head valid.
REQ-019 Port out_pc  out  32  head pc.
REQ-020 Port out_instr  out  32  head instruction.
REQ-021 Port out_bubble  out  1  head invalid this cycle because of redirect; equals !out_valid||br||exn.

Function
REQ-022 Fetch pointer fpc SHALL issue ireq=1 with iaddr=fpc when (queue count + outstanding) < DEPTH, outstanding < MAX_OUT, and no redirect is active; on grant fpc SHALL become fpc+4, wrapping modulo 2^32.
REQ-023 Each ivalid response not marked as discard SHALL push {pc, idata} to the queue tail in request order.
REQ-024 Head SHALL be consumed when out_valid && !stall && !br && !exn.
REQ-025 Redirect target SHALL be: exn&&eret -> elr; exn&&!eret -> {RESET_VEC[31:8], exn_type, 2'b00}; else br -> br_dest.
REQ-026 exn SHALL take priority over br when both are asserted in the same cycle; exn SHALL act even while stall=1.
REQ-027 br SHALL be ignored while stall=1.
REQ-028 On an accepted redirect, the next edge SHALL empty the queue, load fpc with the target, and add all in-flight requests to a discard counter; ireq SHALL be 0 in the redirect cycle.
REQ-029 While the discard counter is nonzero, each ivalid SHALL decrement it and SHALL not push.
REQ-030 Requests to the new target MAY issue while discards are pending; the combined total SHALL not exceed MAX_OUT.
REQ-031 A simultaneous push and pop on a full queue SHALL be legal; a push on a full queue without a pop SHALL be impossible by REQ-022.
REQ-032 When the queue is empty, out_valid SHALL be 0; out_pc and out_instr SHALL hold their last values.

Reset
REQ-033 While rst_n=0: fpc=RESET_VEC, queue empty, outstanding=0, discard=0, ireq=0, out_valid=0, iaddr=RESET_VEC, out_pc=0, out_instr=0.
REQ-034 First ireq SHALL assert in the first cycle after rst_n deasserts; responses arriving during reset SHALL be dropped.

Configuration
REQ-035 Macro STAGE_IF_PQ_ALIGN_CHK_EN.
- Defined: a redirect target with [1:0]!=0 SHALL issue no request, push one entry with out_instr=32'h0 and add output out_misalign=1 on that entry, then halt fetching until the next redirect.
- Undefined: port out_misalign SHALL be absent and target[1:0] SHALL be forced to 0.

Verification
REQ-036 Reset with RESET_VEC=32'h100, igrant=1, 1-cycle memory, stall=0 -> out_pc SHALL be 100,104,108 on consecutive cycles.
REQ-037 DEPTH=4, stall held high -> exactly 4 entries fill, then ireq=0; release stall -> 4 pops, then fetching resumes.
REQ-038 br=1, br_dest=32'h2000 with 2 requests in flight -> both responses discarded; next out_pc=32'h2000.
REQ-039 exn=1, exn_type=6'h05, br=1, stall=1 on the same cycle -> next fetch iaddr={RESET_VEC[31:8],8'h14}.
REQ-040 exn=1, eret=1, elr=32'hFFFF_FFFC -> out_pc sequence FFFFFFFC, 00000000 (wrap).
REQ-041 With STAGE_IF_PQ_ALIGN_CHK_EN defined, br_dest=32'h2002 -> single entry with out_misalign=1 and ireq held at 0 until the next br.
